// File: rtl/sseg_page_scheduler_if.sv
// sseg_page_scheduler_if: page, message and display-side signals of the page scheduler
interface sseg_page_scheduler_if;
  logic [15:0] page0_data;
  logic [15:0] page1_data;
  logic        page1_en;
  logic        hold;
  logic        msg_req;
  logic [15:0] msg_data;
  logic        msg_ack;
  logic [15:0] data;
  logic        blank;
  logic        page;
  logic        msg_active;
  modport master (
    output page0_data, page1_data, page1_en, hold, msg_req, msg_data,
    input  msg_ack, data, blank, page, msg_active
  );
  modport slave (
    input  page0_data, page1_data, page1_en, hold, msg_req, msg_data,
    output msg_ack, data, blank, page, msg_active
  );
endinterface

// File: rtl/sseg_page_scheduler.sv
// sseg_page_scheduler: rotates two status pages with blank gaps and lets a message pre-empt them
module sseg_page_scheduler #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 2_500_000,
  parameter int MSG_CYCLES   = 150_000_000
) (
  input logic                  clk_50M,
  input logic                  reset,
  sseg_page_scheduler_if.slave bus
);
  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ?
    ((DWELL_CYCLES > MSG_CYCLES) ? DWELL_CYCLES : MSG_CYCLES) :
    ((BLANK_CYCLES > MSG_CYCLES) ? BLANK_CYCLES : MSG_CYCLES);
  localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] MSG_LAST   = CW'(MSG_CYCLES - 1);
  typedef enum logic [1:0] {SHOW, BLANK, MSG} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          page_q, page_d;
  logic          ret_page_q, ret_page_d;
  logic [15:0]   data_q, data_d;
  logic          blank_q, blank_d;
  logic          msg_ack_q, msg_ack_d;
  logic          msg_active_q, msg_active_d;
  logic          accept;
  logic          next_page;
  assign accept    = bus.msg_req && (state_q != MSG);
  assign next_page = bus.page1_en ? ~page_q : 1'b0;
  // Next-state logic: a message wins over any dwell expiry; data reloads whenever the next cycle shows a page
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_d     = page_q;
    ret_page_d = ret_page_q;
    data_d     = data_q;
    msg_ack_d  = 1'b0;
    if (accept) begin
      state_d    = MSG;
      cnt_d      = '0;
      ret_page_d = page_q;
      data_d     = bus.msg_data;
      msg_ack_d  = 1'b1;
    end else begin
      case (state_q)
        SHOW: begin
          if (!bus.hold) begin
            cnt_d = (cnt_q == DWELL_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == DWELL_LAST && next_page != page_q) begin
              state_d = BLANK;
              page_d  = next_page;
            end
          end
        end
        BLANK: begin
          cnt_d   = (cnt_q == BLANK_LAST) ? '0 : cnt_q + CW'(1);
          state_d = (cnt_q == BLANK_LAST) ? SHOW : BLANK;
        end
        MSG: begin
          cnt_d   = (cnt_q == MSG_LAST) ? '0 : cnt_q + CW'(1);
          state_d = (cnt_q == MSG_LAST) ? BLANK : MSG;
          page_d  = (cnt_q == MSG_LAST) ? ret_page_q : page_q;
        end
        default: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      endcase
      data_d = (state_d == SHOW) ? (page_d ? bus.page1_data : bus.page0_data) : data_q;
    end
    blank_d      = (state_d == BLANK);
    msg_active_d = (state_d == MSG);
  end
  // State and registered outputs
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q      <= SHOW;
      cnt_q        <= '0;
      page_q       <= 1'b0;
      ret_page_q   <= 1'b0;
      data_q       <= 16'h0000;
      blank_q      <= 1'b0;
      msg_ack_q    <= 1'b0;
      msg_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      page_q       <= page_d;
      ret_page_q   <= ret_page_d;
      data_q       <= data_d;
      blank_q      <= blank_d;
      msg_ack_q    <= msg_ack_d;
      msg_active_q <= msg_active_d;
    end
  end
  assign bus.data       = data_q;
  assign bus.blank      = blank_q;
  assign bus.page       = page_q;
  assign bus.msg_ack    = msg_ack_q;
  assign bus.msg_active = msg_active_q;
endmodule

// File: tb/tb_sseg_page_scheduler.sv
// tb_sseg_page_scheduler: directed and random checks of the page scheduler against a countdown model
module tb_sseg_page_scheduler;
  localparam int DW = 8;
  localparam int BC = 2;
  localparam int MC = 5;
  localparam int PH_SHOW = 0;
  localparam int PH_BLANK = 1;
  localparam int PH_MSG = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  bit started = 0;
  sseg_page_scheduler_if bus();
  sseg_page_scheduler #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BC), .MSG_CYCLES(MC)) dut (
    .clk_50M(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Model: each phase has a number of cycles left; a page shows for DW unheld cycles, a blank for BC, a message for MC
  int m_phase, m_left;
  logic m_page, m_ret, m_ack;
  logic [15:0] m_data;
  always @(posedge clk) begin
    if (reset) begin
      m_phase = PH_SHOW; m_left = DW; m_page = 0; m_ret = 0; m_data = 0; m_ack = 0; started = 1;
    end else if (started) begin
      m_ack = 0;
      if (m_phase != PH_MSG && bus.msg_req) begin
        m_ack = 1; m_ret = m_page; m_data = bus.msg_data; m_phase = PH_MSG; m_left = MC;
      end else if (m_phase == PH_SHOW) begin
        if (!bus.hold) m_left--;
        if (m_left == 0) begin
          m_left = DW;
          if ((bus.page1_en ? !m_page : 1'b0) != m_page) begin
            m_page = !m_page; m_phase = PH_BLANK; m_left = BC;
          end
        end
      end else if (m_phase == PH_BLANK) begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_SHOW; m_left = DW; end
      end else begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_BLANK; m_left = BC; m_page = m_ret; end
      end
      if (m_phase == PH_SHOW) m_data = m_page ? bus.page1_data : bus.page0_data;
    end
  end
  // Every cycle: all DUT outputs against the model
  always @(negedge clk) begin
    if (started)
      chk("cycle {data,blank,page,active,ack}",
          {12'h0, bus.data, bus.blank, bus.page, bus.msg_active, bus.msg_ack},
          {12'h0, m_data, m_phase == PH_BLANK, m_page, m_phase == PH_MSG, m_ack});
  end
  task automatic lit(input string name, input logic [15:0] d, input logic b, input logic p);
    chk({name, " data"}, {16'h0, bus.data}, {16'h0, d});
    chk({name, " blank"}, {31'h0, bus.blank}, {31'h0, b});
    chk({name, " page"}, {31'h0, bus.page}, {31'h0, p});
  endtask
  initial begin
    int blanks;
    bus.page0_data = 16'h1234; bus.page1_data = 16'hABCD; bus.page1_en = 1;
    bus.hold = 0; bus.msg_req = 0; bus.msg_data = 16'h0;
    tick(2);
    reset = 0;
    lit("reset", 16'h0000, 0, 0);
    chk("reset active", {31'h0, bus.msg_active}, 32'h0);
    chk("reset ack", {31'h0, bus.msg_ack}, 32'h0);
    tick(1); lit("page0 shown", 16'h1234, 0, 0);
    tick(6); lit("page0 last dwell", 16'h1234, 0, 0);
    tick(1); lit("blank to page1", 16'h1234, 1, 1);
    tick(1); lit("blank 2", 16'h1234, 1, 1);
    tick(1); lit("page1 shown", 16'hABCD, 0, 1);
    tick(7); lit("page1 last dwell", 16'hABCD, 0, 1);
    tick(1); lit("blank to page0", 16'hABCD, 1, 0);
    tick(2); lit("page0 again", 16'h1234, 0, 0);
    tick(3);
    bus.msg_req = 1; bus.msg_data = 16'hE001;
    tick(1); lit("msg accept", 16'hE001, 0, 0);
    chk("msg ack pulse", {31'h0, bus.msg_ack}, 32'h1);
    bus.msg_req = 0;
    tick(4); chk("msg still active", {31'h0, bus.msg_active}, 32'h1);
    tick(1); lit("msg end blank", 16'hE001, 1, 0);
    tick(2); lit("return page0", 16'h1234, 0, 0);
    tick(7); lit("full dwell after msg", 16'h1234, 0, 0);
    tick(1); lit("blank toward page1", 16'h1234, 1, 1);
    bus.msg_req = 1; bus.msg_data = 16'h1111;
    tick(1); lit("msg in blank", 16'h1111, 0, 1);
    bus.msg_data = 16'h2222;
    tick(4); chk("no ack during msg", {31'h0, bus.msg_ack}, 32'h0);
    tick(1); lit("held req blank", 16'h1111, 1, 1);
    tick(1); lit("second msg", 16'h2222, 0, 1);
    chk("second ack", {31'h0, bus.msg_ack}, 32'h1);
    bus.msg_req = 0;
    tick(5); lit("second msg blank", 16'h2222, 1, 1);
    tick(2); lit("return page1", 16'hABCD, 0, 1);
    tick(8); tick(2); lit("page0 before expiry msg", 16'h1234, 0, 0);
    tick(7);
    bus.msg_req = 1; bus.msg_data = 16'h3333;
    tick(1); lit("msg at expiry", 16'h3333, 0, 0);
    bus.msg_req = 0;
    tick(5); lit("expiry msg blank", 16'h3333, 1, 0);
    tick(2); lit("no switch to page1", 16'h1234, 0, 0);
    tick(3); bus.hold = 1; tick(20); bus.hold = 0;
    tick(4); lit("held dwell", 16'h1234, 0, 0);
    tick(1); lit("held dwell expiry", 16'h1234, 1, 1);
    bus.page1_en = 0;
    tick(2); lit("page1 after en drop", 16'hABCD, 0, 1);
    tick(7); lit("page1 keeps dwell", 16'hABCD, 0, 1);
    tick(1); lit("back to page0", 16'hABCD, 1, 0);
    tick(2);
    blanks = 0;
    repeat (30) begin tick(1); blanks += int'(bus.blank); end
    chk("no blank with page1 off", blanks, 0);
    bus.page1_en = 1;
    tick(20);
    bus.msg_req = 1; bus.msg_data = 16'h4444;
    tick(1); chk("pre-reset ack", {31'h0, bus.msg_ack}, 32'h1);
    tick(2);
    reset = 1;
    tick(1); lit("reset in msg", 16'h0000, 0, 0);
    chk("reset clears active", {31'h0, bus.msg_active}, 32'h0);
    chk("reset no ack", {31'h0, bus.msg_ack}, 32'h0);
    reset = 0; bus.msg_req = 0;
    tick(1); lit("after reset", 16'h1234, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      reset = ($urandom % 500) == 0;
      bus.hold = ($urandom % 10) == 0;
      if (($urandom % 40) == 0) bus.page1_en = ~bus.page1_en;
      if (($urandom % 6) == 0) bus.page0_data = 16'($urandom);
      if (($urandom % 6) == 0) bus.page1_data = 16'($urandom);
      if (bus.msg_ack) bus.msg_req = 0;
      else if (!bus.msg_req && ($urandom % 12) == 0) begin
        bus.msg_req = 1; bus.msg_data = 16'($urandom);
      end
    end
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
